// File: rtl/arb_pkg.sv
// Shared definitions for the sram-like 2:1 arbiter.
//   arb_state_t : FSM state encoding (IDLE / ADDR / DATA)
//   OWN_*       : owner encoding of the in-flight transaction
//   SIZE_*      : sram-like transfer size encoding
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational winner selection between instruction and data requesters.
// Optional macro ARB_ROUND_ROBIN_EN:
//   defined   - simultaneous requests go to the side NOT granted last
//   undefined - fixed data priority
// Ports:
//   i_req, d_req : pending requests
//   last_grant   : owner of the previous grant (round-robin build only)
//   grant_vld    : some request is pending
//   grant_own    : winning owner (OWN_INST / OWN_DATA)
module arb_grant_sel
    import arb_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic last_grant,
`endif
    output logic grant_vld,
    output logic grant_own
);

    assign grant_vld = i_req | d_req;

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, hand the grant to whoever did not get the last one.
    assign grant_own = (i_req & d_req) ? ~last_grant : d_req;
`else
    assign grant_own = d_req ? OWN_DATA : OWN_INST;
`endif

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges the core's instruction (read-only) and data sram-like ports into a
// single sram-like master port. One transaction in flight at a time; the
// owner register steers addr_ok / data_ok / rdata back to the requester.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
// Ports:
//   clk, rst           : clock (rising edge), async active-low reset
//   i_req/i_addr       : instruction fetch request
//   i_addr_ok/i_data_ok/i_rdata : fetch handshakes and data
//   d_req/d_wr/d_size/d_addr/d_wdata : data request
//   d_addr_ok/d_data_ok/d_rdata : data handshakes and read data
//   s_*                : downstream sram-like master port
module sram_like_arbiter
    import arb_pkg::*;
#(
    parameter int         ADDR_W    = 32,
    parameter int         DATA_W    = 32,
    parameter logic [1:0] INST_SIZE = SIZE_WORD
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_addr_ok,
    output logic              i_data_ok,

    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,

    output logic              s_req,
    output logic              s_wr,
    output logic [1:0]        s_size,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_addr_ok,
    input  logic              s_data_ok
);

    arb_state_t state;
    logic       owner;
    logic       grant_vld;
    logic       grant_own;
    logic       own_addr_ok;
    logic       own_data_ok;

`ifdef ARB_ROUND_ROBIN_EN
    logic       last_grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            last_grant <= OWN_DATA;
        else if (state == ST_IDLE && grant_vld)
            last_grant <= grant_own;
    end
`endif

    arb_grant_sel u_grant_sel (
        .i_req      (i_req),
        .d_req      (d_req),
`ifdef ARB_ROUND_ROBIN_EN
        .last_grant (last_grant),
`endif
        .grant_vld  (grant_vld),
        .grant_own  (grant_own)
    );

    // The grant is registered: IDLE spends one cycle choosing the owner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            owner <= OWN_INST;
        end else begin
            case (state)
                ST_IDLE: if (grant_vld) begin
                    owner <= grant_own;
                    state <= ST_ADDR;
                end
                // Zero-latency slave: data_ok together with addr_ok skips DATA.
                ST_ADDR: if (s_addr_ok) state <= s_data_ok ? ST_IDLE : ST_DATA;
                ST_DATA: if (s_data_ok) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        s_req       = 1'b0;
        s_wr        = 1'b0;
        s_size      = 2'd0;
        s_addr      = '0;
        s_wdata     = '0;
        i_addr_ok   = 1'b0;
        i_data_ok   = 1'b0;
        i_rdata     = '0;
        d_addr_ok   = 1'b0;
        d_data_ok   = 1'b0;
        d_rdata     = '0;

        own_addr_ok = (state == ST_ADDR) & s_addr_ok;
        own_data_ok = s_data_ok & ((state == ST_DATA) | own_addr_ok);

        if (state == ST_ADDR) begin
            s_req = 1'b1;
            if (owner == OWN_DATA) begin
                s_wr    = d_wr;
                s_size  = d_size;
                s_addr  = d_addr;
                s_wdata = d_wdata;
            end else begin
                s_size  = INST_SIZE;
                s_addr  = i_addr;
            end
        end

        // Only the owner ever sees handshakes or data.
        if (owner == OWN_DATA) begin
            d_addr_ok = own_addr_ok;
            d_data_ok = own_data_ok;
            d_rdata   = own_data_ok ? s_rdata : '0;
        end else begin
            i_addr_ok = own_addr_ok;
            i_data_ok = own_data_ok;
            i_rdata   = own_data_ok ? s_rdata : '0;
        end
    end

`ifndef SYNTHESIS
    // A data_ok with no outstanding address handshake is dropped by the FSM.
    a_stray_data_ok: assert property (@(posedge clk) disable iff (!rst)
        !(s_data_ok && (state == ST_IDLE || (state == ST_ADDR && !s_addr_ok))));
`endif

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
Two-to-one arbiter that merges the core's instruction sram-like port (read-only) and data sram-like port into one sram-like master port toward the AXI bridge.
Sits between mips_core and the AXI interface block.
Allows exactly one transaction in flight, tracks which requester owns it, and routes addr_ok, data_ok and rdata back to that owner only.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
INST_SIZE, 2'b10, s_size driven for instruction fetches (word)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
i_req  in  1  instruction fetch request, held until i_addr_ok
i_addr  in  ADDR_W  fetch address
i_rdata  out  DATA_W  fetch data, valid with i_data_ok
i_addr_ok  out  1  fetch address accepted
i_data_ok  out  1  fetch data returned
d_req  in  1  data request, held until d_addr_ok
d_wr  in  1  1=write, 0=read
d_size  in  2  0=byte, 1=half, 2=word
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_rdata  out  DATA_W  read data, valid with d_data_ok
d_addr_ok  out  1  data address accepted
d_data_ok  out  1  data read returned or write completed
s_req  out  1  downstream request
s_wr  out  1  downstream write flag
s_size  out  2  downstream size
s_addr  out  ADDR_W  downstream address
s_wdata  out  DATA_W  downstream write data
s_rdata  in  DATA_W  downstream read data
s_addr_ok  in  1  downstream address accepted
s_data_ok  in  1  downstream data/completion

Behaviour:
- States: IDLE, ADDR, DATA. Registers: state and owner (0=inst, 1=data). Reset: state=IDLE, owner=0.
- All outputs are 0 in reset and in IDLE.
- IDLE: if any request is pending, latch the winner into owner and go to ADDR.
  - Default policy is fixed data priority: d_req wins over i_req.
  - The grant is registered, so arbitration costs one cycle.
- ADDR:
  - s_req=1. s_wr, s_size, s_addr and s_wdata mux combinationally from the owner.
  - Inst owner drives s_wr=0, s_size=INST_SIZE, s_wdata=0.
  - owner_addr_ok = s_addr_ok. The non-owner's addr_ok and data_ok stay 0.
  - On s_addr_ok go to DATA.
  - If s_data_ok arrives in the same cycle as s_addr_ok (zero-latency slave), forward both to the owner and go directly to IDLE.
- DATA:
  - s_req=0.
  - On s_data_ok: owner_data_ok=1 and owner_rdata=s_rdata for exactly that cycle, then go to IDLE.
- rdata to the non-owner is forced to 0.
- Minimum fetch cost: IDLE→ADDR→DATA is 3 cycles with a 1-cycle slave.
- Back-to-back: return to IDLE costs one bubble cycle before the next grant.
- A requester dropping req in ADDR is a protocol violation. The grant is held regardless until s_addr_ok.
- s_data_ok in IDLE or ADDR without a matching handshake is ignored; the simulation assertion fires.
- Reset asserted mid-transaction returns to IDLE immediately. The downstream slave is reset with the same rst.

Optional Feature:
ARB_ROUND_ROBIN_EN.
- Defined: a last-granted bit, reset to 1 (data), decides simultaneous requests. The requester not granted last wins, so a fetch is never starved by a stream of loads/stores.
- Undefined: fixed data priority as above, and the last-granted bit is not built.

Decomposition:
- Shared package arb_pkg: state encoding (ST_IDLE=2'd0, ST_ADDR=2'd1, ST_DATA=2'd2), OWN_INST/OWN_DATA, and SIZE_BYTE/HALF/WORD.
- One natural sub-module, arb_grant_sel: combinational winner selection, with round-robin under the macro.
- FSM and muxing stay in the top module.

Test Plan:
- i_req=1, i_addr=0xBFC00000; slave addr_ok after 1 cycle, data_ok 2 cycles later with rdata=0x3C1D0001 → i_addr_ok pulses once, i_rdata=0x3C1D0001 with i_data_ok, d_* outputs stay 0.
- i_req and d_req both rise in the same cycle, d_wr=1, d_addr=0x80001000, d_wdata=0xDEADBEEF, d_size=2 → the data write goes out first; the fetch is granted in the cycle after the write's s_data_ok plus one IDLE bubble.
- Same stimulus with ARB_ROUND_ROBIN_EN defined after reset → the fetch is granted first (last-granted=data), then the data write.
- Zero-latency slave (s_addr_ok=s_data_ok=1 in ADDR) → the owner sees addr_ok and data_ok in the same cycle; the FSM goes ADDR→IDLE with no DATA cycle.
- rst driven low while in DATA → all outputs 0 asynchronously; after release, a pending i_req is granted normally.
- Slave stalls s_addr_ok for 5 cycles → s_req stays 1 with s_addr stable; d_req arriving meanwhile is not granted until the current transaction completes.
